// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command parser: FSM states,
// header bytes, scope register map and frame lengths for both build variants.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DHI  = 3'd3,
    ST_DLO  = 3'd4,
    ST_CSUM = 3'd5
  } state_t;

  localparam logic [7:0] HDR0_DEF = 8'h55;
  localparam logic [7:0] HDR1_DEF = 8'hAA;

  localparam logic [7:0] ADDR_TRIG_LVL = 8'h01;
  localparam logic [7:0] ADDR_TIMEBASE = 8'h02;
  localparam logic [7:0] ADDR_CH_EN    = 8'h03;

  localparam int FRAME_LEN_PLAIN = 5;
  localparam int FRAME_LEN_CSUM  = 6;

  // 8-bit wrap-around sum of the three payload bytes.
  function automatic logic [7:0] csum8(input logic [7:0] addr,
                                       input logic [7:0] data_hi,
                                       input logic [7:0] data_lo);
    return addr + data_hi + data_lo;
  endfunction

endpackage

// File: rtl/uart_byte_strobe.sv
// Turns the receiver's level-style uart_done into one strobe per byte and
// presents the byte (live in the strobe cycle, held afterwards).
module uart_byte_strobe #(
  parameter int DATA_W = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              uart_done,
  input  logic [DATA_W-1:0] uart_data,
  output logic              byte_stb,
  output logic [DATA_W-1:0] byte_data
);

  logic              done_d;
  logic [DATA_W-1:0] byte_q;

  // done_d resets high so a uart_done already asserted at reset release is not a new byte.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) done_d <= 1'b1;
    else            done_d <= uart_done;
  end

  always_ff @(posedge sys_clk) begin
    if (byte_stb) byte_q <= uart_data;
  end

  assign byte_stb  = uart_done & ~done_d;
  assign byte_data = byte_stb ? uart_data : byte_q;

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 55 AA addr hi lo [csum] frames into one-cycle register-write commands.
// Build option: define UART_CMD_CSUM_EN to add and check the trailing checksum byte.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int         CLK_FREQ    = 200000000,
  parameter int         TIMEOUT_CYC = 2000000,
  parameter logic [7:0] HDR0        = HDR0_DEF,
  parameter logic [7:0] HDR1        = HDR1_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        uart_done,
  input  logic [7:0]  uart_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        frame_err,
  output logic        busy
);

  localparam int              CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  if (TIMEOUT_CYC < 1 || CLK_FREQ < 1) begin : g_param_check
    $error("uart_cmd_parser: TIMEOUT_CYC and CLK_FREQ must be >= 1");
  end

  logic       byte_stb;
  logic [7:0] byte_data;

  uart_byte_strobe #(.DATA_W(8)) u_byte_strobe (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .uart_done (uart_done),
    .uart_data (uart_data),
    .byte_stb  (byte_stb),
    .byte_data (byte_data)
  );

  state_t           state, state_nxt;
  logic [CNT_W-1:0] to_cnt;
  logic             timeout;
  logic             issue, csum_bad, ld_addr, ld_dhi;
  logic [7:0]       addr_r, dhi_r, lo_byte;
`ifdef UART_CMD_CSUM_EN
  logic             ld_dlo;
  logic [7:0]       dlo_r;
`endif

  // A byte arriving in the would-be timeout cycle takes precedence.
  assign timeout = (state != ST_IDLE) && !byte_stb && (to_cnt == CNT_LAST);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = ST_IDLE;
    end else if (byte_stb) begin
      case (state)
        ST_IDLE: if (byte_data == HDR0) state_nxt = ST_HDR;
        ST_HDR: begin
          if      (byte_data == HDR1) state_nxt = ST_ADDR;
          else if (byte_data == HDR0) state_nxt = ST_HDR;
          else                        state_nxt = ST_IDLE;
        end
        ST_ADDR: state_nxt = ST_DHI;
        ST_DHI:  state_nxt = ST_DLO;
`ifdef UART_CMD_CSUM_EN
        ST_DLO:  state_nxt = ST_CSUM;
        ST_CSUM: state_nxt = ST_IDLE;
`else
        ST_DLO:  state_nxt = ST_IDLE;
`endif
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    issue    = 1'b0;
    csum_bad = 1'b0;
    ld_addr  = 1'b0;
    ld_dhi   = 1'b0;
`ifdef UART_CMD_CSUM_EN
    ld_dlo   = 1'b0;
`endif
    if (byte_stb) begin
      case (state)
        ST_ADDR: ld_addr = 1'b1;
        ST_DHI:  ld_dhi  = 1'b1;
`ifdef UART_CMD_CSUM_EN
        ST_DLO:  ld_dlo  = 1'b1;
        ST_CSUM: begin
          if (byte_data == csum8(addr_r, dhi_r, dlo_r)) issue    = 1'b1;
          else                                          csum_bad = 1'b1;
        end
`else
        ST_DLO:  issue   = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                           to_cnt <= '0;
    else if (byte_stb || !busy || timeout)    to_cnt <= '0;
    else                                      to_cnt <= to_cnt + CNT_W'(1);
  end

  // Partial-frame fields carry no reset; they are only consumed after being loaded.
  always_ff @(posedge sys_clk) begin
    if (ld_addr) addr_r <= byte_data;
    if (ld_dhi)  dhi_r  <= byte_data;
`ifdef UART_CMD_CSUM_EN
    if (ld_dlo)  dlo_r  <= byte_data;
`endif
  end

`ifdef UART_CMD_CSUM_EN
  assign lo_byte = dlo_r;
`else
  assign lo_byte = byte_data;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
    end else begin
      cmd_valid <= issue;
      frame_err <= timeout | csum_bad;
      if (issue) begin
        cmd_addr <= addr_r;
        cmd_data <= {dhi_r, lo_byte};
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: frames are built from plain byte lists,
// expected commands/errors are queued at send time and a monitor checks outputs.
module tb_uart_cmd_parser;

  localparam int TO = 1000;
`ifdef UART_CMD_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        uart_done = 1'b0;
  logic [7:0]  uart_data = 8'h00;
  logic        cmd_valid, frame_err, busy;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;

  uart_cmd_parser #(.CLK_FREQ(100000000), .TIMEOUT_CYC(TO)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .uart_done (uart_done),
    .uart_data (uart_data),
    .cmd_valid (cmd_valid),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit          is_err;
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  last_addr = 8'h00;
  logic [15:0] last_data = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every output pulse must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n === 1'b1 && (cmd_valid !== 1'b0 || frame_err !== 1'b0)) begin
        check("valid_and_err_exclusive", {31'd0, cmd_valid & frame_err}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_output", {30'd0, cmd_valid, frame_err}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("output_kind_err", {31'd0, frame_err}, {31'd0, e.is_err});
          check("cmd_addr", {24'd0, cmd_addr}, {24'd0, e.addr});
          check("cmd_data", {16'd0, cmd_data}, {16'd0, e.data});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    @(negedge sys_clk);
    uart_data = b;
    uart_done = 1'b1;
    repeat (hold) @(negedge sys_clk);
    uart_done = 1'b0;
    uart_data = 8'($urandom);
    if (gap > 1) repeat (gap - 1) @(negedge sys_clk);
  endtask

  function automatic int rhold();
    return int'($urandom_range(1, 40));
  endfunction

  function automatic int rgap();
    return int'($urandom_range(1, 10));
  endfunction

  // Frame byte list: npre copies of 0x55, 0xAA, payload, optional checksum.
  function automatic void build_frame(output logic [7:0] fr[$], input logic [7:0] a,
                                      input logic [7:0] h, input logic [7:0] l,
                                      input int npre, input bit bad);
    logic [7:0] c;
    fr = {};
    for (int i = 0; i < npre; i++) fr.push_back(8'h55);
    fr.push_back(8'hAA);
    fr.push_back(a);
    fr.push_back(h);
    fr.push_back(l);
    c = 8'((int'(a) + int'(h) + int'(l)) % 256);
    if (bad) c = c + 8'd1;
    if (CSUM) fr.push_back(c);
  endfunction

  task automatic expect_cmd(input logic [7:0] a, input logic [15:0] d);
    exp_t e;
    e.is_err = 1'b0; e.addr = a; e.data = d;
    exp_q.push_back(e);
    last_addr = a;
    last_data = d;
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1; e.addr = last_addr; e.data = last_data;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l,
                            input int npre, input bit bad, input int hold);
    logic [7:0] fr[$];
    build_frame(fr, a, h, l, npre, bad && CSUM);
    if (bad && CSUM) expect_err();
    else             expect_cmd(a, {h, l});
    foreach (fr[i]) send_byte(fr[i], (hold > 0) ? hold : rhold(), rgap());
  endtask

  task automatic send_junk();
    int n;
    logic [7:0] b;
    n = int'($urandom_range(0, 3));
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        send_byte(8'h55, rhold(), rgap());
        do b = 8'($urandom); while (b == 8'h55 || b == 8'hAA);
        send_byte(b, rhold(), rgap());
      end else begin
        do b = 8'($urandom); while (b == 8'h55);
        send_byte(b, rhold(), rgap());
      end
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 4 * TO) begin
      @(negedge sys_clk);
      k++;
    end
    repeat (3) @(negedge sys_clk);
    check("expectations_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [7:0] fr[$];
    int         tl;

    repeat (4) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("reset_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_cmd_addr", {24'd0, cmd_addr}, 32'd0);
    check("reset_cmd_data", {16'd0, cmd_data}, 32'd0);

    // Long uart_done level per byte.
    send_frame(8'h03, 8'h12, 8'h34, 1, 1'b0, 780);
    wait_drain();

    // Resync on repeated header.
    send_frame(8'h01, 8'h00, 8'h80, 2, 1'b0, 0);
    wait_drain();

    // Timeout after a partial frame; held outputs must not move.
    send_byte(8'h55, rhold(), rgap());
    send_byte(8'hAA, rhold(), rgap());
    send_byte(8'h02, rhold(), rgap());
    check("busy_mid_frame", {31'd0, busy}, 32'd1);
    expect_err();
    repeat (TO + 20) @(negedge sys_clk);
    check("busy_after_timeout", {31'd0, busy}, 32'd0);
    send_frame(8'h02, 8'hBE, 8'hEF, 1, 1'b0, 0);
    wait_drain();

    // Byte landing exactly in the timeout cycle is accepted.
    expect_cmd(8'h03, 16'h5678);
    build_frame(fr, 8'h03, 8'h56, 8'h78, 1, 1'b0);
    foreach (fr[i]) send_byte(fr[i], 5, (i == 2) ? TO - 5 : 2);
    wait_drain();

    // One cycle later the frame has already timed out; remaining bytes fall into IDLE.
    expect_err();
    build_frame(fr, 8'h03, 8'h56, 8'h78, 1, 1'b0);
    foreach (fr[i]) send_byte(fr[i], 5, (i == 2) ? TO - 4 : 2);
    wait_drain();
    check("busy_after_late_byte", {31'd0, busy}, 32'd0);

    // Checksum mismatch then match (no-op distinction in the plain build).
    send_frame(8'h03, 8'h12, 8'h34, 1, 1'b1, 0);
    send_frame(8'h03, 8'h12, 8'h34, 1, 1'b0, 0);
    wait_drain();

    // Checksum wrap-around.
    send_frame(8'hFF, 8'hFF, 8'h02, 1, 1'b0, 0);
    wait_drain();

    // uart_done high through reset release must not produce a byte.
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    uart_data = 8'h55;
    uart_done = 1'b1;
    last_addr = 8'h00;
    last_data = 16'h0000;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    check("busy_after_release_done_high", {31'd0, busy}, 32'd0);
    uart_done = 1'b0;
    repeat (3) @(negedge sys_clk);
    send_frame(ADDR_VAL(1), 8'h0A, 8'h0B, 1, 1'b0, 0);
    wait_drain();

    // Reset in the middle of a frame.
    send_byte(8'h55, rhold(), rgap());
    send_byte(8'hAA, rhold(), rgap());
    send_byte(8'h01, rhold(), rgap());
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("busy_in_reset", {31'd0, busy}, 32'd0);
    check("cmd_addr_in_reset", {24'd0, cmd_addr}, 32'd0);
    last_addr = 8'h00;
    last_data = 16'h0000;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    send_frame(8'h02, 8'h44, 8'h55, 1, 1'b0, 0);
    wait_drain();

    // Randomized traffic.
    for (int it = 0; it < 30; it++) begin
      int         kind;
      logic [7:0] a;
      kind = int'($urandom_range(0, 7));
      a = ($urandom_range(0, 1) == 0) ? ADDR_VAL(int'($urandom_range(0, 2))) : 8'($urandom);
      send_junk();
      if (kind == 7) begin
        build_frame(fr, a, 8'($urandom), 8'($urandom), 1, 1'b0);
        tl = int'($urandom_range(1, fr.size() - 1));
        expect_err();
        for (int i = 0; i < tl; i++) send_byte(fr[i], rhold(), rgap());
        repeat (TO + 10) @(negedge sys_clk);
      end else begin
        send_frame(a, 8'($urandom), 8'($urandom), int'($urandom_range(1, 3)), kind == 6, 0);
      end
    end
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  function automatic logic [7:0] ADDR_VAL(input int i);
    case (i)
      0:       return 8'h01;
      1:       return 8'h02;
      default: return 8'h03;
    endcase
  endfunction

  initial begin
    #50_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART receiver in the remote-oscilloscope sender.
- Consumes received bytes and assembles fixed-format command frames from the host: header, register address, 16-bit value and optional checksum.
- Emits one-cycle register-write commands to the scope control logic (trigger level, timebase, channel enable).
- Flags malformed or stalled frames.

Parameters:
- CLK_FREQ, 200000000, sys_clk frequency in Hz; informational only, used only to document the timeout.
- TIMEOUT_CYC, 2000000, number of idle sys_clk cycles allowed between bytes of one frame (10 ms at 200 MHz); must be ≥ 1.
- HDR0, 8'h55, first header byte.
- HDR1, 8'hAA, second header byte.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- uart_done  in  1  byte-received flag from the receiver; a level that may stay high for many cycles per byte.
- uart_data  in  8  received byte; valid while uart_done is high.
- cmd_valid  out  1  one-cycle pulse: cmd_addr/cmd_data hold a complete valid command.
- cmd_addr  out  8  register address of the command.
- cmd_data  out  16  register value, {data_hi, data_lo}.
- frame_err  out  1  one-cycle pulse on a timeout or checksum failure.
- busy  out  1  high while a frame is partially received (state ≠ IDLE).

Behaviour:
- Reset values: cmd_valid=0, cmd_addr=0, cmd_data=0, frame_err=0, busy=0, state=IDLE, timeout counter=0.
- Byte strobe:
  - done_d is a register of uart_done; byte_stb = uart_done & ~done_d.
  - done_d resets to 1, so a uart_done already high at reset release produces no strobe.
  - Exactly one strobe per received byte, regardless of how long uart_done stays high.
  - uart_data is sampled in the byte_stb cycle.
- FSM states: IDLE, HDR, ADDR, DHI, DLO, CSUM. All transitions below occur only on byte_stb.
  - IDLE: byte==HDR0 -> HDR; any other byte is ignored.
  - HDR: byte==HDR1 -> ADDR; byte==HDR0 -> stay in HDR (resync on a repeated 0x55); any other byte -> IDLE, with no frame_err.
  - ADDR: latch addr -> DHI.
  - DHI: latch data_hi -> DLO.
  - DLO: latch data_lo; next state is CSUM when the option is enabled, otherwise IDLE with the command issued.
  - CSUM: compare against the checksum -> IDLE.
- Header bytes appearing inside the payload are treated as plain data; there is no escaping.
- Outputs:
  - cmd_addr/cmd_data update together with cmd_valid, in the cycle after the byte_stb of the final byte.
  - They hold their values until the next valid command; cmd_valid is high for exactly 1 cycle.
- Timeout:
  - The counter runs only when state ≠ IDLE and clears on every byte_stb.
  - When it reaches TIMEOUT_CYC-1 without a strobe: state -> IDLE, frame_err pulses 1 cycle, partial fields are discarded and cmd_* are unchanged.
  - If byte_stb coincides with the timeout cycle, the byte wins: it is processed normally and no frame_err is raised.
- No back-pressure: the consumer must accept cmd_valid in the cycle it is asserted. Maximum command rate is one per frame.
- Asserting sys_rst_n low mid-frame discards the frame immediately; after release the parser waits for a new HDR0.

Optional Feature:
- UART_CMD_CSUM_EN defined:
  - Frames are 6 bytes long; the 6th byte is the checksum, computed as (addr + data_hi + data_lo) mod 256 in 8-bit wrap-around arithmetic.
  - On a match: cmd_valid pulses.
  - On a mismatch: frame_err pulses 1 cycle, there is no cmd_valid and cmd_* are unchanged.
- UART_CMD_CSUM_EN undefined:
  - Frames are 5 bytes long; the CSUM state and checksum logic are not built.
  - cmd_valid follows the DLO byte, and frame_err comes only from a timeout.

Decomposition:
- Package uart_cmd_pkg:
  - FSM state enum (3-bit).
  - HDR0/HDR1 default constants.
  - Register address map constants: ADDR_TRIG_LVL=8'h01, ADDR_TIMEBASE=8'h02, ADDR_CH_EN=8'h03.
  - Frame length constants for both build variants.
- Sub-module uart_byte_strobe: the uart_done edge detector with done_d reset to 1, outputting byte_stb and the registered byte. It is reusable by other UART consumers.

Test Plan:
1. Send 55 AA 03 12 34 (plus checksum 49 when CSUM_EN is defined), with uart_done held high for 780 cycles per byte -> one cmd_valid, cmd_addr=03, cmd_data=1234, frame_err never asserted.
2. Send 55 55 AA 01 00 80 (plus checksum 81) -> resync on the repeated 0x55 works; cmd_addr=01, cmd_data=0080.
3. Send 55 AA 02, then wait TIMEOUT_CYC cycles -> frame_err pulses 1 cycle, busy falls, and cmd_* keep their previous values. Then send a full valid frame -> it is accepted.
4. With UART_CMD_CSUM_EN: send 55 AA 03 12 34 48 -> frame_err pulse and no cmd_valid. Then send the same frame with checksum 49 -> cmd_valid.
5. Checksum wrap: send 55 AA FF FF 02 with checksum 00 -> cmd_data=FF02 and cmd_valid asserted.
6. Hold uart_done high through reset release, and assert reset mid-frame after 55 AA 01 -> no strobe on release, busy=0, and the next full frame decodes correctly.
